// File: rtl/stack_sequencer.sv
// Stack micro-sequencer: runs PUSH rp, POP rp, CALL and RET one at a time by
// driving the register-file control port and the 8-bit memory bus.
module stack_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  cmd,
  input  logic [1:0]  pair,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rf_read_sel,
  input  logic [15:0] rf_out,
  output logic [4:0]  rf_load_sel,
  output logic        rf_load,
  output logic [1:0]  rf_op,
  output logic [15:0] rf_data,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata
);

  localparam logic [4:0] SP_SEL = 5'b11010;
  localparam logic [4:0] PC_SEL = 5'b11000;
  localparam logic [4:0] WZ_SEL = 5'b10110;

  localparam logic [1:0] CMD_PUSH = 2'b00;
  localparam logic [1:0] CMD_POP  = 2'b01;
  localparam logic [1:0] CMD_CALL = 2'b10;
  localparam logic [1:0] CMD_RET  = 2'b11;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;

  typedef enum logic [3:0] {
    IDLE, FETCH, SPDEC, WRH, WRL, RDL, RDH, WB, JMP
  } state_t;

  state_t      state_q;
  logic [1:0]  cmd_q;
  logic [1:0]  pair_q;
  logic [15:0] tmp_q;
  logic        done_q;
  logic [4:0]  pairSel;

  assign pairSel = {1'b1, 1'b0, pair_q, 1'b0};
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= CMD_PUSH;
      pair_q  <= 2'b00;
      tmp_q   <= 16'h0000;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cmd_q  <= cmd;
            pair_q <= pair;
            state_q <= (cmd == CMD_PUSH || cmd == CMD_CALL) ? FETCH : RDL;
          end
        end
        FETCH: begin
          tmp_q   <= rf_out;
          state_q <= SPDEC;
        end
        SPDEC: state_q <= WRH;
        WRH:   state_q <= WRL;
        WRL: begin
          if (cmd_q == CMD_CALL) begin
            state_q <= JMP;
          end else begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        JMP: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        RDL: state_q <= RDH;
        // Low byte from the RDL read lands now; the high byte arrives during WB.
        RDH: begin
          tmp_q[7:0] <= mem_rdata;
          state_q    <= WB;
        end
        WB: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset suppresses every output in the cycle it is seen, so an aborted
  // sequence issues no strobe at the aborting edge.
  always_comb begin
    rf_read_sel = 5'b00000;
    rf_load_sel = 5'b00000;
    rf_load     = 1'b0;
    rf_op       = OP_NONE;
    rf_data     = 16'h0000;
    mem_addr    = 16'h0000;
    mem_wdata   = 8'h00;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: rf_read_sel = (cmd_q == CMD_CALL) ? PC_SEL : pairSel;
        SPDEC: begin
          rf_load_sel = SP_SEL;
          rf_op       = OP_DEC;
        end
        WRH: begin
          rf_read_sel = SP_SEL;
          mem_addr    = rf_out;
          mem_wdata   = tmp_q[15:8];
          mem_we      = 1'b1;
          rf_load_sel = SP_SEL;
          rf_op       = OP_DEC;
        end
        WRL: begin
          rf_read_sel = SP_SEL;
          mem_addr    = rf_out;
          mem_wdata   = tmp_q[7:0];
          mem_we      = 1'b1;
        end
        RDL, RDH: begin
          rf_read_sel = SP_SEL;
          mem_addr    = rf_out;
          mem_re      = 1'b1;
          rf_load_sel = SP_SEL;
          rf_op       = OP_INC;
        end
        WB: begin
          rf_data     = {mem_rdata, tmp_q[7:0]};
          rf_load_sel = (cmd_q == CMD_RET) ? PC_SEL : pairSel;
          rf_load     = 1'b1;
        end
        JMP: begin
          rf_read_sel = WZ_SEL;
          rf_data     = rf_out;
          rf_load_sel = PC_SEL;
          rf_load     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: register-file and memory models around the DUT,
// with a scoreboard of expected memory writes and reads.
module tb_stack_sequencer;

  localparam logic [2:0] BC_I = 3'd0;
  localparam logic [2:0] DE_I = 3'd1;
  localparam logic [2:0] HL_I = 3'd2;
  localparam logic [2:0] WZ_I = 3'd3;
  localparam logic [2:0] SP_I = 3'd4;
  localparam logic [2:0] PC_I = 3'd5;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  cmd;
  logic [1:0]  pair;
  logic        busy;
  logic        done;
  logic [4:0]  rf_read_sel;
  logic [15:0] rf_out;
  logic [4:0]  rf_load_sel;
  logic        rf_load;
  logic [1:0]  rf_op;
  logic [15:0] rf_data;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;

  logic [15:0] rf [0:7];
  logic [7:0]  mem [0:65535];

  logic        regPokeEn;
  logic [2:0]  regPokeIdx;
  logic [15:0] regPokeVal;
  logic        memPokeEn;
  logic [15:0] memPokeAddr;
  logic [7:0]  memPokeVal;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         wrQ [$];
  logic [15:0] rdQ [$];

  int testCount = 0;
  int failCount = 0;
  int doneCount = 0;

  stack_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cmd        (cmd),
    .pair       (pair),
    .busy       (busy),
    .done       (done),
    .rf_read_sel(rf_read_sel),
    .rf_out     (rf_out),
    .rf_load_sel(rf_load_sel),
    .rf_load    (rf_load),
    .rf_op      (rf_op),
    .rf_data    (rf_data),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] selIdx(input logic [4:0] s);
    case (s)
      5'b10000: return BC_I;
      5'b10010: return DE_I;
      5'b10100: return HL_I;
      5'b10110: return WZ_I;
      5'b11010: return SP_I;
      5'b11000: return PC_I;
      default:  return 3'd7;
    endcase
  endfunction

  always_comb begin
    rf_out = 16'h0000;
    if (selIdx(rf_read_sel) != 3'd7) rf_out = rf[selIdx(rf_read_sel)];
  end

  // Register file and memory behave like the real neighbours: ops at the edge,
  // read data one cycle after mem_re.
  always @(posedge clk) begin
    if (regPokeEn) rf[regPokeIdx] <= regPokeVal;
    else if (rf_load) rf[selIdx(rf_load_sel)] <= rf_data;
    else if (rf_op == 2'b01) rf[selIdx(rf_load_sel)] <= rf[selIdx(rf_load_sel)] + 16'd1;
    else if (rf_op == 2'b10) rf[selIdx(rf_load_sel)] <= rf[selIdx(rf_load_sel)] - 16'd1;
    else if (rf_op == 2'b11) rf[selIdx(rf_load_sel)] <= rf[selIdx(rf_load_sel)] + 16'd2;
    if (memPokeEn) mem[memPokeAddr] <= memPokeVal;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("weReExcl", 64'(mem_we && mem_re), 64'd0);
      checkOutput("loadOpExcl", 64'(rf_load && rf_op != 2'b00), 64'd0);
      if (mem_we) begin
        checkOutput("wrExpected", 64'(wrQ.size() != 0), 64'd1);
        if (wrQ.size() != 0) begin
          wr_t e;
          e = wrQ.pop_front();
          checkOutput("wrAddr", 64'(mem_addr), 64'(e.addr));
          checkOutput("wrData", 64'(mem_wdata), 64'(e.data));
        end
      end
      if (mem_re) begin
        checkOutput("rdExpected", 64'(rdQ.size() != 0), 64'd1);
        if (rdQ.size() != 0) checkOutput("rdAddr", 64'(mem_addr), 64'(rdQ.pop_front()));
      end
      if (done) doneCount++;
    end
  end

  task automatic pokeReg(input logic [2:0] idx, input logic [15:0] val);
    regPokeEn = 1'b1; regPokeIdx = idx; regPokeVal = val;
    @(negedge clk);
    regPokeEn = 1'b0;
  endtask

  task automatic pokeMem(input logic [15:0] addr, input logic [7:0] val);
    memPokeEn = 1'b1; memPokeAddr = addr; memPokeVal = val;
    @(negedge clk);
    memPokeEn = 1'b0;
  endtask

  task automatic expectWrite(input logic [15:0] addr, input logic [7:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    wrQ.push_back(e);
  endtask

  // Called on a falling edge; cmd/pair are scrambled after acceptance so a
  // sequence that does not latch them goes wrong.
  task automatic applyStimulus(input logic [1:0] c, input logic [1:0] p, input int expBusy, input string tag);
    int cyc;
    int d0;
    d0 = doneCount;
    start = 1'b1; cmd = c; pair = p;
    @(negedge clk);
    start = 1'b0; cmd = ~c; pair = ~p;
    cyc = 0;
    while (busy && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    checkOutput({tag, "_busyLen"}, 64'(cyc), 64'(expBusy));
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    checkOutput({tag, "_idleBus"},
                64'({rf_read_sel, rf_load_sel, rf_op, rf_data, mem_addr, mem_wdata}), 64'd0);
    @(negedge clk);
    checkOutput({tag, "_doneOnce"}, 64'(doneCount - d0), 64'd1);
  endtask

  initial begin
    int cyc;
    int d0;
    rst = 1'b1; start = 1'b0; cmd = 2'b00; pair = 2'b00;
    regPokeEn = 1'b0; regPokeIdx = 3'd0; regPokeVal = 16'h0000;
    memPokeEn = 1'b0; memPokeAddr = 16'h0000; memPokeVal = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstDone", 64'(done), 64'd0);
    checkOutput("rstStrobes", 64'({mem_we, mem_re, rf_load, rf_op}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idleBus", 64'({rf_read_sel, rf_load_sel, rf_op, rf_data, mem_addr, mem_wdata}), 64'd0);

    pokeReg(BC_I, 16'h1234);
    pokeReg(SP_I, 16'h2000);
    expectWrite(16'h1FFF, 8'h12);
    expectWrite(16'h1FFE, 8'h34);
    applyStimulus(2'b00, 2'b00, 4, "pushBC");
    checkOutput("pushBC_sp", 64'(rf[SP_I]), 64'h1FFE);
    checkOutput("pushBC_mHi", 64'(mem[16'h1FFF]), 64'h12);
    checkOutput("pushBC_mLo", 64'(mem[16'h1FFE]), 64'h34);

    rdQ.push_back(16'h1FFE);
    rdQ.push_back(16'h1FFF);
    applyStimulus(2'b01, 2'b01, 3, "popDE");
    checkOutput("popDE_de", 64'(rf[DE_I]), 64'h1234);
    checkOutput("popDE_sp", 64'(rf[SP_I]), 64'h2000);

    pokeReg(PC_I, 16'h0105);
    pokeReg(WZ_I, 16'h3000);
    expectWrite(16'h1FFF, 8'h01);
    expectWrite(16'h1FFE, 8'h05);
    applyStimulus(2'b10, 2'b00, 5, "call");
    checkOutput("call_pc", 64'(rf[PC_I]), 64'h3000);
    checkOutput("call_sp", 64'(rf[SP_I]), 64'h1FFE);
    checkOutput("call_mHi", 64'(mem[16'h1FFF]), 64'h01);
    checkOutput("call_mLo", 64'(mem[16'h1FFE]), 64'h05);

    rdQ.push_back(16'h1FFE);
    rdQ.push_back(16'h1FFF);
    applyStimulus(2'b11, 2'b00, 3, "ret");
    checkOutput("ret_pc", 64'(rf[PC_I]), 64'h0105);
    checkOutput("ret_sp", 64'(rf[SP_I]), 64'h2000);

    pokeReg(HL_I, 16'hABCD);
    pokeReg(SP_I, 16'h0000);
    expectWrite(16'hFFFF, 8'hAB);
    expectWrite(16'hFFFE, 8'hCD);
    applyStimulus(2'b00, 2'b10, 4, "pushWrap");
    checkOutput("pushWrap_sp", 64'(rf[SP_I]), 64'hFFFE);
    checkOutput("pushWrap_mHi", 64'(mem[16'hFFFF]), 64'hAB);
    checkOutput("pushWrap_mLo", 64'(mem[16'hFFFE]), 64'hCD);

    pokeMem(16'hFFFF, 8'h5A);
    pokeMem(16'h0000, 8'hC3);
    pokeReg(SP_I, 16'hFFFF);
    rdQ.push_back(16'hFFFF);
    rdQ.push_back(16'h0000);
    applyStimulus(2'b01, 2'b00, 3, "popWrap");
    checkOutput("popWrap_bc", 64'(rf[BC_I]), 64'hC35A);
    checkOutput("popWrap_sp", 64'(rf[SP_I]), 64'h0001);

    // PUSH DE with a POP request held high into the busy window, then a POP HL
    // started in the done cycle.
    pokeReg(SP_I, 16'h3000);
    expectWrite(16'h2FFF, 8'h12);
    expectWrite(16'h2FFE, 8'h34);
    rdQ.push_back(16'h2FFE);
    rdQ.push_back(16'h2FFF);
    d0 = doneCount;
    start = 1'b1; cmd = 2'b00; pair = 2'b01;
    @(negedge clk);
    cmd = 2'b01; pair = 2'b10;
    cyc = 0;
    while (busy && cyc < 20) begin
      cyc++;
      if (cyc == 2) start = 1'b0;
      @(negedge clk);
    end
    checkOutput("ignore_busyLen", 64'(cyc), 64'd4);
    checkOutput("ignore_done", 64'(done), 64'd1);
    checkOutput("ignore_sp", 64'(rf[SP_I]), 64'h2FFE);
    start = 1'b1; cmd = 2'b01; pair = 2'b10;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_accept", 64'(busy), 64'd1);
    cyc = 0;
    while (busy && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    checkOutput("b2b_busyLen", 64'(cyc), 64'd3);
    @(negedge clk);
    checkOutput("b2b_doneCount", 64'(doneCount - d0), 64'd2);
    checkOutput("b2b_hl", 64'(rf[HL_I]), 64'h1234);
    checkOutput("b2b_sp", 64'(rf[SP_I]), 64'h3000);

    // Reset lands while CALL is in WRL: only the high-byte write survives.
    pokeMem(16'h1FFE, 8'h00);
    pokeMem(16'h1FFF, 8'h00);
    pokeReg(PC_I, 16'h0105);
    pokeReg(WZ_I, 16'h3000);
    pokeReg(SP_I, 16'h2000);
    expectWrite(16'h1FFF, 8'h01);
    start = 1'b1; cmd = 2'b10; pair = 2'b00;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_strobes", 64'({mem_we, mem_re, rf_load, rf_op}), 64'd0);
    checkOutput("abort_pc", 64'(rf[PC_I]), 64'h0105);
    checkOutput("abort_sp", 64'(rf[SP_I]), 64'h1FFE);
    checkOutput("abort_mHi", 64'(mem[16'h1FFF]), 64'h01);
    checkOutput("abort_mLo", 64'(mem[16'h1FFE]), 64'h00);

    checkOutput("wrQEmpty", 64'(wrQ.size()), 64'd0);
    checkOutput("rdQEmpty", 64'(rdQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Micro-sequencer that executes the SAP-3 stack operations PUSH rp, POP rp, CALL and RET. It does this by driving the register-file control port (select, load and inc/dec op) and an 8-bit memory bus. It sits beside the instruction controller, which hands it one command at a time and holds off its own register-file and memory traffic while `busy` is high. CALL takes its target from the WZ pair, which the fetch logic has already loaded.

## Interface
- `SP_SEL`, 5'b11010, register-file pair select for SPH:SPL.
- `PC_SEL`, 5'b11000, pair select for PCH:PCL.
- `WZ_SEL`, 5'b10110, pair select for W:Z.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  command strobe, sampled only in IDLE.
- `cmd`  in  2  00=PUSH, 01=POP, 10=CALL, 11=RET.
- `pair`  in  2  00=BC, 01=DE, 10=HL, 11=WZ (PUSH/POP only). Select is {1'b1, 1'b0, pair, 1'b0}.
- `busy`  out  1  high while a sequence owns the register-file and memory ports.
- `done`  out  1  one-cycle pulse after a sequence completes.
- `rf_read_sel`  out  5  register-file read select; bit 4 selects pair mode.
- `rf_out`  in  16  register-file combinational read data.
- `rf_load_sel`  out  5  register-file load/op target.
- `rf_load`  out  1  register-file load strobe.
- `rf_op`  out  2  00 none, 01 INC, 10 DEC, 11 INC2.
- `rf_data`  out  16  register-file load data.
- `mem_addr`  out  16  memory address.
- `mem_wdata`  out  8  memory write data.
- `mem_we`  out  1  memory write strobe.
- `mem_re`  out  1  memory read strobe; `mem_rdata` is valid the following cycle.
- `mem_rdata`  in  8  memory read data.

## Operation
- States:
  - IDLE
  - FETCH: source pair → `tmp[15:0]` at the edge.
  - SPDEC: load_sel=SP, op=DEC.
  - WRH: read SP; `mem_addr`=rf_out; `mem_wdata`=tmp[15:8]; we=1; load_sel=SP; op=DEC.
  - WRL: read SP; `mem_addr`=rf_out; `mem_wdata`=tmp[7:0]; we=1.
  - RDL: read SP; addr=rf_out; re=1; load_sel=SP; op=INC.
  - RDH: same as RDL; tmp[7:0]←mem_rdata.
  - WB: `rf_data`={mem_rdata, tmp[7:0]}; load_sel=destination; load=1.
  - JMP: read WZ; `rf_data`=rf_out; load_sel=PC; load=1.
- Sequences:
  - PUSH: FETCH(pair) → SPDEC → WRH → WRL → IDLE.
  - POP: RDL → RDH → WB(pair) → IDLE.
  - CALL: FETCH(PC) → SPDEC → WRH → WRL → JMP → IDLE.
  - RET: RDL → RDH → WB(PC) → IDLE.
- Never assert `rf_load` and a non-zero `rf_op` in the same cycle.
- Never assert `mem_we` and `mem_re` together.
- In IDLE, and in any state where they are unused, all outputs are 0: selects 0, op 00, strobes 0, data 0.
- SP arithmetic is 16-bit modulo 2^16; wrap is silent.
- `start` while busy is ignored; there is no queueing.
- `pair`/`cmd` are captured at acceptance, so later changes do not affect the running sequence.

## Timing
- Reset: state=IDLE, busy=0, done=0, tmp=0, all strobes 0. This holds after the first rising edge with `rst`=1.
- Reset mid-sequence aborts at that edge. Writes already performed remain, as does any partial SP change, and no further strobes are issued.
- When `start` is sampled in IDLE at edge N, the first sequence state occupies cycle N+1.
- busy length: PUSH 4 cycles, POP 3, CALL 5, RET 3.
- `done`=1 in the cycle after the final state, with busy=0. A new `start` is accepted in that same cycle.
- Memory read latency is exactly 1 cycle. The WB state consumes the data from the RDH read.

## Test plan
- PUSH BC, B=12 C=34 SP=2000: M[1FFF]=12, M[1FFE]=34, SP=1FFE, busy for 4 cycles, done once.
- POP DE after that: D=12, E=34, SP=2000, busy for 3 cycles.
- CALL, PC=0105 WZ=3000 SP=2000: M[1FFF]=01, M[1FFE]=05, PC=3000, SP=1FFE. Then RET: PC=0105, SP=2000.
- Wrap:
  - PUSH HL (H=AB L=CD), SP=0000: M[FFFF]=AB, M[FFFE]=CD, SP=FFFE.
  - POP from SP=FFFF: reads FFFF then 0000, SP=0001.
- `start` pulsed during the PUSH busy window with cmd=POP: ignored, memory and SP match a lone PUSH. Back-to-back start accepted in the done cycle.
- `rst` asserted during the WRL cycle of CALL: next cycle busy=0, no strobes, PC unchanged, SP=1FFE, M[1FFF]=01 only.
